or1200_enc_fsm: RTL and testbench
=================================

# or1200_enc_fsm

Encryption-side control FSM of the OR1200 secure cache path. On every cache data return it captures the returned word and its address, then derives a per-address pad from the session key over a fixed number of rounds. It emits the decrypted word and a one-cycle `unstall_o` pulse. `unstall_o` drives the `enc_fsm_unstall` input of the downstream ack-delay FSM, which holds the cache ack until this pulse arrives.

## Interface
Parameters:
- `ROUNDS`, default 4: pad-generation rounds, legal range 1..15.

Ports:
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: **synchronous, active-high** reset.
- `req_i` input, 1 bit: cache data-return strobe, the same signal as the ack-delay FSM's `ack_i`.
- `addr_i` input, 32 bits: physical word address of the returned data. Sampled with `req_i`.
- `dat_i` input, 32 bits: ciphertext word from the cache. Sampled with `req_i`.
- `key_i` input, 32 bits: session key. Sampled with `req_i`.
- `key_valid_i` input, 1 bit: encryption enabled. When low, the block runs in bypass mode.
- `dat_o` output, 32 bits: decrypted (or bypassed) word. Held until the next capture completes.
- `unstall_o` output, 1 bit: one-cycle pulse marking `dat_o` valid. Connects to `enc_fsm_unstall`.
- `busy_o` output, 1 bit: high in every state except IDLE.
- `overrun_o` output, 1 bit: sticky flag, set when `req_i` arrives while not in IDLE. Cleared only by `rst`.

## Operation
- States: IDLE, GEN, DONE. All state and outputs are registered.
- Reset values: state = IDLE, `dat_o` = 0, `unstall_o` = 0, `busy_o` = 0, `overrun_o` = 0, internal `pad` = 0, `cnt` = 0, captured data = 0, captured key = 0.
- IDLE, with `req_i` high and `key_valid_i` high:
  - Latch `dat_i` and `key_i`.
  - Load `pad` <= `addr_i` ^ `key_i` and `cnt` <= 1.
  - Go to GEN.
- IDLE, with `req_i` high and `key_valid_i` low (bypass):
  - Set `dat_o` <= `dat_i` and `unstall_o` <= 1.
  - Go to DONE.
- IDLE, with `req_i` low: remain in IDLE.
- GEN, on each clock edge:
  - `pad` <= rotl(`pad`, 5) + (`key` ^ {28'b0, `cnt`}), with the sum taken mod 2^32.
  - `cnt` <= `cnt` + 1.
  - `key` here is the latched copy, not `key_i`.
- GEN exit: on the edge where `cnt` == `ROUNDS`, apply the final round and go to DONE. On that same edge:
  - `dat_o` <= captured data ^ (final pad value, i.e. the combinational next-pad).
  - `unstall_o` <= 1.
- DONE: `unstall_o` is high for exactly this one cycle. Next edge: `unstall_o` <= 0, go to IDLE.
- `req_i` in GEN or DONE is ignored for data purposes. It sets `overrun_o` and does not disturb the operation in progress.
- `key_i`, `addr_i` and `key_valid_i` changing during GEN have no effect.
- Reset asserted mid-operation: the next edge forces all reset values. No `unstall_o` pulse is produced for the aborted request.

## Timing
- Let `req_i` be sampled high at the edge closing cycle T.
- Encrypted path:
  - GEN occupies cycles T+1 .. T+ROUNDS.
  - `unstall_o` and valid `dat_o` appear in cycle T+ROUNDS+1.
  - Latency is ROUNDS+1 cycles.
  - The block is back in IDLE in cycle T+ROUNDS+2. The earliest next accepted `req_i` is sampled at the end of that cycle.
- Bypass path: `unstall_o` is high in cycle T+1 and the block returns to IDLE in cycle T+2.
- `unstall_o` is never high in the cycle `req_i` is sampled. The downstream ack-delay FSM therefore always enters its wait state and is released by this pulse.
- `busy_o` is high from cycle T+1 through the DONE cycle inclusive.
- `dat_o` changes only on the edge that raises `unstall_o`.

## Test plan
- Reset check: hold `rst` for 3 cycles with random inputs driven, then release. Required: all outputs 0, `busy_o` 0, no `unstall_o` pulse.
- Default `ROUNDS`=4, with `key_i`=0, `addr_i`=0, `dat_i`=0x12345678, `key_valid_i`=1, and `req_i` pulsed at cycle T:
  - Required pad sequence: 1, 0x22, 0x443, 0x8864.
  - Required: `dat_o`=0x1234DE1C with a single-cycle `unstall_o` in cycle T+5.
  - Required: `busy_o` high in cycles T+1..T+5.
- Bypass: `key_valid_i`=0, `dat_i`=0xCAFEF00D, `req_i` pulsed at cycle T. Required: `dat_o`=0xCAFEF00D and `unstall_o` high in cycle T+1 only.
- Overrun: issue a second `req_i` at cycle T+2, during GEN. Required:
  - The first result is unchanged and arrives in cycle T+5.
  - `overrun_o` rises in cycle T+3 and stays high until `rst`.
- Mid-operation reset: assert `rst` at cycle T+2. Required: no `unstall_o` pulse, `dat_o`=0, and the block is IDLE in cycle T+3. A fresh request afterwards produces correct results.
- Integration with the ack-delay FSM, with `ack_i` tied to `req_i`. Required:
  - `delayed_ack_o` stays high from T+1 through T+ROUNDS+1.
  - `delayed_ack_o` drops in cycle T+ROUNDS+2.
  - Repeat for 100 back-to-back requests with random key/addr/data, each scoreboarded against a reference model.

Source files
------------

// File: rtl/or1200_enc_fsm_if.sv
// ---------------------------------------------------------------------------
// Module : or1200_enc_fsm_if
// Cache data-return / decrypted-word bundle between the cache side and the
// encryption control FSM.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface or1200_enc_fsm_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic [31:0] dat_i;
  logic [31:0] key_i;
  logic        key_valid_i;
  logic [31:0] dat_o;
  logic        unstall_o;
  logic        busy_o;
  logic        overrun_o;

  modport master (
    output req_i, addr_i, dat_i, key_i, key_valid_i,
    input  dat_o, unstall_o, busy_o, overrun_o
  );

  modport slave (
    input  req_i, addr_i, dat_i, key_i, key_valid_i,
    output dat_o, unstall_o, busy_o, overrun_o
  );
endinterface

`default_nettype wire

// File: rtl/or1200_enc_fsm.sv
// ---------------------------------------------------------------------------
// Module : or1200_enc_fsm
// Derives a per-address pad from the session key over ROUNDS rounds, XORs it
// onto the returned cache word and pulses unstall for the ack-delay FSM.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module or1200_enc_fsm #(
  parameter int ROUNDS = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  or1200_enc_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  state_t      state;
  logic [31:0] pad;
  logic [31:0] data;
  logic [31:0] key;
  logic [3:0]  cnt;
  logic [31:0] dat_out;
  logic        unstall;
  logic        busy;
  logic        overrun;
  logic [31:0] next_pad;

  // One round: rotate left by 5, then add the latched key salted with the round number.
  always_comb begin
    next_pad = {pad[26:0], pad[31:27]} + (key ^ {28'h0, cnt});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pad     <= 32'h0;
      data    <= 32'h0;
      key     <= 32'h0;
      cnt     <= 4'h0;
      dat_out <= 32'h0;
      unstall <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (bus.req_i && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            busy <= 1'b1;
            if (bus.key_valid_i) begin
              data  <= bus.dat_i;
              key   <= bus.key_i;
              pad   <= bus.addr_i ^ bus.key_i;
              cnt   <= 4'h1;
              state <= GEN;
            end else begin
              dat_out <= bus.dat_i;
              unstall <= 1'b1;
              state   <= DONE;
            end
          end
        end
        GEN: begin
          pad <= next_pad;
          cnt <= cnt + 4'h1;
          if (cnt == LAST_RND) begin
            dat_out <= data ^ next_pad;
            unstall <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          unstall <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          unstall <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.dat_o     = dat_out;
  assign bus.unstall_o = unstall;
  assign bus.busy_o    = busy;
  assign bus.overrun_o = overrun;

endmodule

`default_nettype wire

// File: tb/tb_or1200_enc_fsm.sv
// ---------------------------------------------------------------------------
// Module : tb_or1200_enc_fsm
// Self-checking bench for or1200_enc_fsm with a behavioural pad model and a
// small model of the downstream ack-delay FSM.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_or1200_enc_fsm;

  localparam int R = 4;

  logic clk;
  logic rst;
  logic dack;
  int   tests_run;
  int   failed;

  or1200_enc_fsm_if bus ();

  or1200_enc_fsm #(.ROUNDS(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ack-delay FSM: ack raises delayed ack, the unstall pulse releases it.
  always @(posedge clk) begin
    if (rst)               dack <= 1'b0;
    else if (bus.req_i)    dack <= 1'b1;
    else if (bus.unstall_o) dack <= 1'b0;
  end

  function automatic logic [31:0] ref_dec(input logic [31:0] a, input logic [31:0] d,
                                          input logic [31:0] k, input logic v);
    logic [31:0] p;
    if (!v) return d;
    p = a ^ k;
    for (int i = 1; i <= R; i++) begin
      p = ((p << 5) | (p >> 27)) + (k ^ 32'(i));
    end
    return d ^ p;
  endfunction

  function automatic logic [31:0] win(input int lo, input int hi);
    logic [31:0] m;
    m = 32'h0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in the current cycle, then records per-cycle output bits.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [31:0] k,
                         input logic v, input int len, input int extra,
                         output logic [31:0] umask, output logic [31:0] bmask,
                         output logic [31:0] dmask, output logic [31:0] omask,
                         output logic [31:0] dout);
    umask = 32'h0; bmask = 32'h0; dmask = 32'h0; omask = 32'h0; dout = 32'h0;
    bus.addr_i = a; bus.dat_i = d; bus.key_i = k; bus.key_valid_i = v; bus.req_i = 1'b1;
    umask[0] = bus.unstall_o; bmask[0] = bus.busy_o; dmask[0] = dack; omask[0] = bus.overrun_o;
    for (int c = 1; c <= len; c++) begin
      step();
      bus.req_i       = (c == extra);
      bus.addr_i      = $urandom;
      bus.dat_i       = $urandom;
      bus.key_i       = $urandom;
      bus.key_valid_i = 1'($urandom_range(0, 1));
      umask[c] = bus.unstall_o; bmask[c] = bus.busy_o;
      dmask[c] = dack;          omask[c] = bus.overrun_o;
      if (bus.unstall_o) dout = bus.dat_o;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.req_i = 1'($urandom_range(0, 1)); bus.key_valid_i = 1'($urandom_range(0, 1));
      bus.addr_i = $urandom; bus.dat_i = $urandom; bus.key_i = $urandom;
      step();
      tests_run++;
      if ({bus.dat_o, bus.unstall_o, bus.busy_o, bus.overrun_o} !== 35'h0) begin
        failed++;
        $display("FAIL reset_hold: dat=%h unstall=%b busy=%b overrun=%b, required all 0",
                 bus.dat_o, bus.unstall_o, bus.busy_o, bus.overrun_o);
      end
    end
    rst = 1'b0; bus.req_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if ({bus.dat_o, bus.unstall_o, bus.busy_o, bus.overrun_o} !== 35'h0) begin
        failed++;
        $display("FAIL reset_release: dat=%h unstall=%b busy=%b overrun=%b, required all 0",
                 bus.dat_o, bus.unstall_o, bus.busy_o, bus.overrun_o);
      end
    end
  endtask

  task automatic test_vector();
    logic [31:0] u, b, dm, o, d;
    run_txn(32'h0, 32'h12345678, 32'h0, 1'b1, R + 2, -1, u, b, dm, o, d);
    tests_run++;
    if (d !== 32'h1234DE1C) begin
      failed++; $display("FAIL vector_data: got %h, required 1234de1c", d);
    end
    tests_run++;
    if (u !== 32'(1 << (R + 1))) begin
      failed++; $display("FAIL vector_unstall: mask %h, required %h", u, 32'(1 << (R + 1)));
    end
    tests_run++;
    if (b !== win(1, R + 1)) begin
      failed++; $display("FAIL vector_busy: mask %h, required %h", b, win(1, R + 1));
    end
    tests_run++;
    if (bus.dat_o !== 32'h1234DE1C) begin
      failed++; $display("FAIL vector_hold: dat_o %h, required 1234de1c", bus.dat_o);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] u, b, dm, o, d;
    run_txn($urandom, 32'hCAFEF00D, $urandom, 1'b0, 2, -1, u, b, dm, o, d);
    tests_run++;
    if (d !== 32'hCAFEF00D) begin
      failed++; $display("FAIL bypass_data: got %h, required cafef00d", d);
    end
    tests_run++;
    if (u !== 32'h2) begin
      failed++; $display("FAIL bypass_unstall: mask %h, required 00000002", u);
    end
    tests_run++;
    if (b !== 32'h2 || dm !== 32'h2) begin
      failed++; $display("FAIL bypass_busy_ack: busy %h ack %h, required 00000002", b, dm);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] u, b, dm, o, d, a, x, k;
    a = $urandom; x = $urandom; k = $urandom;
    run_txn(a, x, k, 1'b1, R + 2, 2, u, b, dm, o, d);
    tests_run++;
    if (d !== ref_dec(a, x, k, 1'b1) || u !== 32'(1 << (R + 1))) begin
      failed++;
      $display("FAIL overrun_result: data %h mask %h, required %h mask %h",
               d, u, ref_dec(a, x, k, 1'b1), 32'(1 << (R + 1)));
    end
    tests_run++;
    if (o !== win(3, R + 2)) begin
      failed++; $display("FAIL overrun_flag: mask %h, required %h", o, win(3, R + 2));
    end
    run_txn($urandom, $urandom, $urandom, 1'b1, R + 2, -1, u, b, dm, o, d);
    tests_run++;
    if (o !== win(0, R + 2)) begin
      failed++; $display("FAIL overrun_sticky: mask %h, required %h", o, win(0, R + 2));
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] u, b, dm, o, d, a, x, k;
    int pulses;
    bus.addr_i = $urandom; bus.dat_i = $urandom; bus.key_i = $urandom;
    bus.key_valid_i = 1'b1; bus.req_i = 1'b1;
    step();
    bus.req_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if ({bus.dat_o, bus.unstall_o, bus.busy_o, bus.overrun_o} !== 35'h0) begin
      failed++;
      $display("FAIL midreset_state: dat=%h unstall=%b busy=%b overrun=%b, required all 0",
               bus.dat_o, bus.unstall_o, bus.busy_o, bus.overrun_o);
    end
    pulses = 0;
    for (int c = 0; c < R + 3; c++) begin
      step();
      if (bus.unstall_o || bus.busy_o) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      failed++; $display("FAIL midreset_pulse: %0d active cycles, required 0", pulses);
    end
    a = $urandom; x = $urandom; k = $urandom;
    run_txn(a, x, k, 1'b1, R + 2, -1, u, b, dm, o, d);
    tests_run++;
    if (d !== ref_dec(a, x, k, 1'b1) || u !== 32'(1 << (R + 1))) begin
      failed++;
      $display("FAIL midreset_fresh: data %h mask %h, required %h mask %h",
               d, u, ref_dec(a, x, k, 1'b1), 32'(1 << (R + 1)));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] u, b, dm, o, d, a, x, k, eu, eb;
    logic v;
    int len;
    for (int n = 0; n < 100; n++) begin
      a = $urandom; x = $urandom; k = $urandom;
      v = ($urandom_range(0, 7) != 0);
      len = v ? R + 2 : 2;
      eu = v ? 32'(1 << (R + 1)) : 32'h2;
      eb = v ? win(1, R + 1) : 32'h2;
      run_txn(a, x, k, v, len, -1, u, b, dm, o, d);
      tests_run++;
      if (d !== ref_dec(a, x, k, v)) begin
        failed++; $display("FAIL b2b_data[%0d]: got %h, required %h", n, d, ref_dec(a, x, k, v));
      end
      tests_run++;
      if (u !== eu) begin
        failed++; $display("FAIL b2b_unstall[%0d]: mask %h, required %h", n, u, eu);
      end
      tests_run++;
      if (b !== eb) begin
        failed++; $display("FAIL b2b_busy[%0d]: mask %h, required %h", n, b, eb);
      end
      tests_run++;
      if (dm !== eb) begin
        failed++; $display("FAIL b2b_delayed_ack[%0d]: mask %h, required %h", n, dm, eb);
      end
    end
    bus.req_i = 1'b0;
    step();
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    rst = 1'b1;
    bus.req_i = 1'b0; bus.addr_i = 32'h0; bus.dat_i = 32'h0;
    bus.key_i = 32'h0; bus.key_valid_i = 1'b0;
    test_reset();
    test_vector();
    test_bypass();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

`default_nettype wire
